// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage RV32I core.
// Issues pipelined fetches, buffers returned words in order, and discards stale responses after redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [IW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  function automatic idx_t wrap_add(input idx_t base, input cnt_t off);
    int unsigned sum;
    sum = 32'(base) + 32'(off);
    return idx_t'(sum % DEPTH);
  endfunction

  logic [31:0] r_pcf;
  logic [31:0] r_q_pc   [DEPTH];
  logic [31:0] r_q_data [DEPTH];
  idx_t        r_head;
  cnt_t        r_count;    // entries allocated (filled ones form a prefix from head)
  cnt_t        r_nfilled;
  cnt_t        r_discard;  // responses still owed for requests made before a redirect
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc4_d;
  logic        r_valid_d;

  logic [CW:0] w_occupancy;
  cnt_t        w_unfilled;
  logic        w_accept;
  logic        w_rsp_keep;
  logic        w_rsp_drop;
  logic        w_pop_filled;
  logic        w_pop_bypass;
  logic        w_pop;
  logic        w_fill;
  idx_t        w_fill_idx;
  idx_t        w_tail_idx;

  // Discarded requests still count as occupied so the queue can never overflow.
  assign w_occupancy  = {1'b0, r_count} + {1'b0, r_discard};
  assign w_unfilled   = r_count - r_nfilled;
  assign imem_req     = !reset && !StallF && !PCSrcE && (w_occupancy < (CW+1)'(DEPTH));
  assign imem_addr    = r_pcf;
  assign w_accept     = imem_req && imem_ready;
  assign w_rsp_keep   = imem_rvalid && (r_discard == '0);
  assign w_rsp_drop   = imem_rvalid && (r_discard != '0);
  assign w_pop_filled = !StallD && (r_nfilled != '0);
  assign w_pop_bypass = !StallD && (r_nfilled == '0) && (r_count != '0) && w_rsp_keep;
  assign w_pop        = w_pop_filled || w_pop_bypass;
  assign w_fill       = w_rsp_keep && !w_pop_bypass;
  assign w_fill_idx   = wrap_add(r_head, r_nfilled);
  assign w_tail_idx   = wrap_add(r_head, r_count);

  // NOTE: queue storage has no reset; the occupancy counters alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_accept) r_q_pc[w_tail_idx]   <= r_pcf;
    if (w_fill)   r_q_data[w_fill_idx] <= imem_rdata;
  end

  // NOTE: all state updates use non-blocking assignments so every term above sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcf     <= RESET_PC;
      r_head    <= '0;
      r_count   <= '0;
      r_nfilled <= '0;
      r_discard <= '0;
      r_instr_d <= NOP;
      r_pc_d    <= 32'h0000_0000;
      r_pc4_d   <= 32'h0000_0004;
      r_valid_d <= 1'b0;
    end else if (PCSrcE) begin
      // A response arriving now belongs to an unfilled entry and is dropped in place.
      r_pcf     <= {PCTargetE[31:2], 2'b00};
      r_count   <= '0;
      r_nfilled <= '0;
      r_discard <= r_discard + w_unfilled - cnt_t'(imem_rvalid);
      r_instr_d <= NOP;
      r_valid_d <= 1'b0;
    end else begin
      if (w_accept) r_pcf <= r_pcf + 32'd4;
      r_count   <= r_count + cnt_t'(w_accept) - cnt_t'(w_pop);
      r_nfilled <= r_nfilled + cnt_t'(w_fill) - cnt_t'(w_pop_filled);
      r_discard <= r_discard - cnt_t'(w_rsp_drop);
      if (w_pop) r_head <= wrap_add(r_head, cnt_t'(1));
      if (!StallD) begin
        if (w_pop_filled) begin
          r_instr_d <= r_q_data[r_head];
          r_pc_d    <= r_q_pc[r_head];
          r_pc4_d   <= r_q_pc[r_head] + 32'd4;
          r_valid_d <= 1'b1;
        end else if (w_pop_bypass) begin
          r_instr_d <= imem_rdata;
          r_pc_d    <= r_q_pc[r_head];
          r_pc4_d   <= r_q_pc[r_head] + 32'd4;
          r_valid_d <= 1'b1;
        end else begin
          r_instr_d <= NOP;
          r_valid_d <= 1'b0;
        end
      end
    end
  end

  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pc4_d;
  assign ValidD   = r_valid_d;

endmodule
